// File: rtl/blowfish_block_encrypt.sv
// Iterative 16-round Blowfish block encryptor. P-array and S-box tables are
// external synchronous memories: an address issued in one cycle returns data in the next.
module blowfish_block_encrypt (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_block,
    output logic [4:0]   p_addr,
    input  logic [31:0]  p_rdata,
    output logic [31:0]  s_addr,
    input  logic [127:0] s_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        SBOX,
        FEIST,
        FIN_A,
        FIN_B,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  rnd_q, rnd_d;
    logic [31:0] l_q, l_d;
    logic [31:0] r_q, r_d;
    logic [63:0] out_block_q, out_block_d;
    logic [4:0]  p_addr_q, p_addr_d;
    logic [31:0] s_addr_q, s_addr_d;
    logic [31:0] l_xor_p;
    logic [31:0] f_val;

    assign l_xor_p = l_q ^ p_rdata;
    // s_rdata = {S0[a], S1[b], S2[c], S3[d]} for the bytes of the SBOX-cycle address
    assign f_val   = ((s_rdata[127:96] + s_rdata[95:64]) ^ s_rdata[63:32]) + s_rdata[31:0];

    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        l_d         = l_q;
        r_d         = r_q;
        out_block_d = out_block_q;
        p_addr_d    = p_addr_q;
        s_addr_d    = s_addr_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = rst_n;
                p_addr_d = 5'd0;
                if (in_valid && in_ready) begin
                    l_d     = in_block[63:32];
                    r_d     = in_block[31:0];
                    rnd_d   = 4'd0;
                    state_d = SBOX;
                end
            end
            SBOX: begin
                l_d      = l_xor_p;
                s_addr_d = l_xor_p;
                state_d  = FEIST;
            end
            FEIST: begin
                l_d = r_q ^ f_val;
                r_d = l_q;
                if (rnd_q != 4'd15) begin
                    p_addr_d = 5'(rnd_q) + 5'd1;
                    rnd_d    = rnd_q + 4'd1;
                    state_d  = SBOX;
                end else begin
                    p_addr_d = 5'd16;
                    state_d  = FIN_A;
                end
            end
            FIN_A: begin
                // the final un-swap is folded in: l_q now holds the logical R half
                l_d      = l_xor_p;
                p_addr_d = 5'd17;
                state_d  = FIN_B;
            end
            FIN_B: begin
                r_d         = r_q ^ p_rdata;
                out_block_d = {r_q ^ p_rdata, l_q};
                state_d     = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // memory addresses are presented in the cycle they are chosen and held otherwise
    assign p_addr    = p_addr_d;
    assign s_addr    = s_addr_d;
    assign out_block = out_block_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rnd_q       <= 4'd0;
            l_q         <= 32'd0;
            r_q         <= 32'd0;
            out_block_q <= 64'd0;
            p_addr_q    <= 5'd0;
            s_addr_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            l_q         <= l_d;
            r_q         <= r_d;
            out_block_q <= out_block_d;
            p_addr_q    <= p_addr_d;
            s_addr_q    <= s_addr_d;
        end
    end

endmodule
